// File: rtl/memory.sv
// memory: word-addressable register file of 2**M words, N bits each, sitting
// on a shared bidirectional data bus.
//
// Ports:
//   Clock   - system clock; all state changes on the rising edge
//   Reset   - synchronous, active-high; clears every word, wins over a write
//   Select  - word address (every value in range)
//   RW      - 1: write DataBus into word[Select] at the edge
//             0: drive word[Select] onto DataBus combinationally
//   DataBus - shared N-bit bus; this block drives it only while RW = 0
module memory #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 3
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [M-1:0] Select,
  input  logic         RW,
  inout  wire  [N-1:0] DataBus
);

  localparam int unsigned DEPTH = 2 ** M;

  logic [N-1:0] word [DEPTH];

  // Storage update: reset clears all words, otherwise a write captures the bus.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        word[i] <= '0;
      end
    end else if (RW) begin
      word[Select] <= DataBus;
    end
  end

  // Bus driver: enabled by !RW only, so reset never releases or forces the bus.
  assign DataBus = RW ? {N{1'bz}} : word[Select];

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: reset clearing, single and bulk writes, readback,
// bus release while writing, reset-over-write priority, reset after a fill.
module tb_memory;

  logic       Clock;
  logic       Reset;
  logic [2:0] Select;
  logic       RW;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] DataBus;

  int vectors;
  int miscompares;

  assign DataBus = drv_en ? drv_val : 8'bz;

  memory #(.N(8), .M(3)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Select (Select),
    .RW     (RW),
    .DataBus(DataBus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] expected);
    #1;
    vectors++;
    assert (DataBus === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, DataBus, expected);
    end
  endtask

  task automatic read_at(input string tag, input logic [2:0] addr, input logic [7:0] expected);
    Select = addr;
    check($sformatf("%s[%0d]", tag, addr), expected);
  endtask

  // One write edge: master drives val at addr with RW=1, then turns the bus around.
  task automatic write_word(input logic [2:0] addr, input logic [7:0] val);
    Select  = addr;
    drv_val = val;
    drv_en  = 1'b1;
    RW      = 1'b1;
    tick();
    RW      = 1'b0;
    drv_en  = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset   = 1'b1;
    RW      = 1'b0;
    Select  = 3'd0;
    drv_en  = 1'b0;
    drv_val = 8'h00;
    @(negedge Clock);

    // Reset for one edge, then every address reads zero.
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) read_at("reset", 3'(i), 8'h00);

    // Single write of 74 to address 0.
    write_word(3'd0, 8'h4A);
    read_at("single", 3'd0, 8'h4A);
    for (int i = 1; i < 8; i++) read_at("single", 3'(i), 8'h00);

    // Distinct value per address, read back twice.
    for (int i = 0; i < 8; i++) write_word(3'(i), 8'(8'h10 + i));
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) read_at("fill", 3'(i), 8'(8'h10 + i));
    end

    // RW=1 without an edge: the block must not fight the master's 0xAA.
    Select  = 3'd3;
    drv_val = 8'hAA;
    drv_en  = 1'b1;
    RW      = 1'b1;
    check("nodrive", 8'hAA);
    // Master released, RW still 1: the stored 0x13 must not appear on the bus.
    drv_en = 1'b0;
    #1;
    vectors++;
    assert (DataBus !== 8'h13)
    else begin
      miscompares++;
      $error("FAIL release: observed %h expected not 13", DataBus);
    end
    RW = 1'b0;
    read_at("nowrite", 3'd3, 8'h13);

    // Reset on the same edge as a write of 0x55: reset wins everywhere.
    Select  = 3'd3;
    drv_val = 8'h55;
    drv_en  = 1'b1;
    RW      = 1'b1;
    Reset   = 1'b1;
    tick();
    Reset  = 1'b0;
    RW     = 1'b0;
    drv_en = 1'b0;
    read_at("rst_wins", 3'd3, 8'h00);
    read_at("rst_wins", 3'd5, 8'h00);
    write_word(3'd3, 8'h55);
    read_at("after_rst", 3'd3, 8'h55);
    read_at("after_rst", 3'd2, 8'h00);

    // Fill with RW held high while Select moves each edge.
    RW     = 1'b1;
    drv_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Select  = 3'(i);
      drv_val = 8'(8'hF0 + i);
      tick();
    end
    RW     = 1'b0;
    drv_en = 1'b0;
    for (int i = 0; i < 8; i++) read_at("burst", 3'(i), 8'(8'hF0 + i));

    // Reset for one edge after the fill clears every word.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) read_at("clear", 3'(i), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
